// File: rtl/ring_pkg.sv
// Shared definitions for the LED ring controller: FSM state encoding,
// default ring geometry, step counter width and a one-hot test helper.
// Ports: none (package).
package ring_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ring_state_t;

   localparam int RING_DEF_WIDTH = 8;
   localparam int RING_DEF_INIT  = 1;
   localparam int STEP_CNT_W     = 16;

   // True when exactly one bit of v is set (v is zero-extended by callers).
   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/ring_led_ctrl_if.sv
// Control/status bundle of the LED ring controller.
// Ports: en_i, dir_i, load_i, load_val_i (controller inputs);
//        ring_o, step_o, wrap_o, step_cnt_o, err_o (controller outputs).
interface ring_led_ctrl_if
   import ring_pkg::*;
#(
   parameter int WIDTH = RING_DEF_WIDTH
);
   logic                  en_i;
   logic                  dir_i;
   logic                  load_i;
   logic [WIDTH-1:0]      load_val_i;
   logic [WIDTH-1:0]      ring_o;
   logic                  step_o;
   logic                  wrap_o;
   logic [STEP_CNT_W-1:0] step_cnt_o;
   logic                  err_o;

   // master drives the controls and observes the ring
   modport master (
      output en_i, dir_i, load_i, load_val_i,
      input  ring_o, step_o, wrap_o, step_cnt_o, err_o
   );

   // slave is the controller itself
   modport slave (
      input  en_i, dir_i, load_i, load_val_i,
      output ring_o, step_o, wrap_o, step_cnt_o, err_o
   );
endinterface

// File: rtl/ring_led_ctrl_step_sync.sv
// Brings the asynchronous divided clock into clk_i and flags its rising edges.
// Ports: clk_i, sys_rst (sync, active-high), step_i (async), edge_o (1-cycle pulse).
// Latency: edge_o is high in the second cycle after step_i is first sampled high.
module step_sync (
   input  logic clk_i,
   input  logic sys_rst,
   input  logic step_i,
   output logic edge_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk_i) begin
      if (sys_rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= step_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Only the synchronized copy is used, so one step_i rise gives one pulse.
   assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/ring_led_ctrl.sv
// Rotating LED ring: advances one position per step_i rise while enabled.
// Ports: clk_i, sys_rst (sync, active-high), step_i (async divided clock),
//        bus (ring_led_ctrl_if.slave: enable/direction/load in, ring/status out).
// Optional: RING_SELF_CORRECT_EN replaces non-one-hot ring values with INIT and sets err_o.
module ring_led_ctrl
   import ring_pkg::*;
#(
   parameter int               WIDTH = RING_DEF_WIDTH,
   parameter logic [WIDTH-1:0] INIT  = WIDTH'(RING_DEF_INIT)
) (
   input  logic            clk_i,
   input  logic            sys_rst,
   input  logic            step_i,
   ring_led_ctrl_if.slave  bus
);

   logic                  edge_det;
   ring_state_t           state_q;
   logic [WIDTH-1:0]      ring_q;
   logic [WIDTH-1:0]      ring_rot_d;
   logic                  wrap_d;
   logic                  step_q;
   logic                  wrap_q;
   logic [STEP_CNT_W-1:0] cnt_q;
`ifdef RING_SELF_CORRECT_EN
   logic                  err_q;
`endif

   step_sync u_step_sync (
      .clk_i  (clk_i),
      .sys_rst(sys_rst),
      .step_i (step_i),
      .edge_o (edge_det)
   );

   // Rotated ring and the bit that crosses the MSB/LSB boundary, per direction.
   always_comb begin
      ring_rot_d = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
      wrap_d     = ring_q[WIDTH-1];
      if (bus.dir_i) begin
         ring_rot_d = {ring_q[0], ring_q[WIDTH-1:1]};
         wrap_d     = ring_q[0];
      end
   end

   // Priority: reset > load > correction (optional) > advance.
   always_ff @(posedge clk_i) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         ring_q  <= INIT;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef RING_SELF_CORRECT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         step_q <= 1'b0;
         wrap_q <= 1'b0;

         case (state_q)
            ST_IDLE: if (bus.en_i)  state_q <= ST_RUN;
            ST_RUN:  if (!bus.en_i) state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase

         if (bus.load_i) begin
            // Any edge detected this cycle is dropped, not deferred.
            ring_q <= bus.load_val_i;
         end
`ifdef RING_SELF_CORRECT_EN
         else if (!is_onehot(32'(ring_q))) begin
            ring_q <= INIT;
            err_q  <= 1'b1;
         end
`endif
         else if ((state_q == ST_RUN) && edge_det) begin
            ring_q <= ring_rot_d;
            step_q <= 1'b1;
            wrap_q <= wrap_d;
            cnt_q  <= cnt_q + 1'b1;
         end
      end
   end

   assign bus.ring_o     = ring_q;
   assign bus.step_o     = step_q;
   assign bus.wrap_o     = wrap_q;
   assign bus.step_cnt_o = cnt_q;
`ifdef RING_SELF_CORRECT_EN
   assign bus.err_o      = err_q;
`else
   assign bus.err_o      = 1'b0;
`endif

endmodule
